// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Desc     : 8N1 UART transmitter with internal baud counter. Define the
//            macro UART_TX_PARITY_EN to insert an even-parity bit before stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_out_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd4;
`endif

  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] baud_q, baud_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  assign w_bit_end = (baud_q == c_BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at accept because the shift register drains to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != c_IDLE) begin
      baud_d = w_bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      c_IDLE: begin
        if (tx_start_i) begin
          state_d = c_START;
          baud_d  = '0;
          idx_d   = '0;
          shift_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data_i;
`endif
        end
      end
      c_START: begin
        if (w_bit_end) state_d = c_DATA;
      end
      c_DATA: begin
        if (w_bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = c_PARITY;
`else
            state_d = c_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      c_PARITY: begin
        if (w_bit_end) state_d = c_STOP;
      end
`endif
      c_STOP: begin
        if (w_bit_end) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    tx_out_o  = 1'b1;
    tx_busy_o = (state_q != c_IDLE);
    tx_done_o = 1'b0;
    case (state_q)
      c_START:  tx_out_o  = 1'b0;
      c_DATA:   tx_out_o  = shift_q[0];
`ifdef UART_TX_PARITY_EN
      c_PARITY: tx_out_o  = par_q;
`endif
      c_STOP:   tx_done_o = w_bit_end;
      default:  tx_out_o  = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Desc     : Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_out, tx_busy, tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(CLKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start_i (tx_start),
    .tx_data_i  (tx_data),
    .tx_out_o   (tx_out),
    .tx_busy_o  (tx_busy),
    .tx_done_o  (tx_done)
  );

  always #5 clk = ~clk;

  // seq holds the 8N1 line levels, bit i = level during bit time i.
  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    for (int i = 0; i < NBITS; i++) begin
      if (i == 0)                     f[i] = 1'b0;
      else if (i <= 8)                f[i] = d[i-1];
      else if (NBITS == 11 && i == 9) f[i] = ($countones(d) % 2) == 1;
      else                            f[i] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [10:0] vec2exp(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {v.seq[9], v.par, v.seq[8:0]};
`else
    return {1'b0, v.seq};
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " idle out"},  tx_out,  1);
    check({tag, " idle busy"}, tx_busy, 0);
    check({tag, " idle done"}, tx_done, 0);
  endtask

  // Starts at a sample point with the DUT idle; ends one cycle after the frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [10:0] exp,
                           input int repulse_k, input bit hold, input logic [7:0] next_d);
    tx_data  = d;
    tx_start = 1'b1;
    tick;
    tx_start = hold;
    if (hold) tx_data = next_d;
    for (int k = 0; k < NBITS*CLKS; k++) begin
      if (!hold) tx_data = 8'($urandom);
      if (k == repulse_k) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else if (!hold) begin
        tx_start = 1'b0;
      end
      check($sformatf("%s out k=%0d", tag, k),  tx_out,  exp[k/CLKS]);
      check($sformatf("%s busy k=%0d", tag, k), tx_busy, 1);
      check($sformatf("%s done k=%0d", tag, k), tx_done, (k == NBITS*CLKS-1));
      tick;
    end
    if (!hold) tx_start = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    logic [7:0] d;
    int gap;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[2] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[3] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[4] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[5] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[6] = '{8'h5A, 10'b1010110100, 1'b0};
    vecs[7] = '{8'h80, 10'b1100000000, 1'b1};

    rst = 1'b1;
    tick;
    tick;
    check("reset out",  tx_out,  1);
    check("reset busy", tx_busy, 0);
    check("reset done", tx_done, 0);
    rst = 1'b0;
    tick;
    check_idle("post-reset");

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vec2exp(vecs[i]), -1, 1'b0, 8'h00);
      tick;
    end

    // Start request during a busy frame must be ignored.
    run_frame("busy-repulse", 8'hA5, vec2exp(vecs[0]), 13, 1'b0, 8'h00);
    tick;

    // Held start: second frame begins after exactly one idle cycle.
    run_frame("b2b0", 8'h00, vec2exp(vecs[3]), -1, 1'b1, 8'h81);
    run_frame("b2b1", 8'h81, vec2exp(vecs[4]), -1, 1'b0, 8'h00);
    tick;

    // Asynchronous reset in the middle of data bit 3.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    repeat (17) tick;
    check("pre-rst out",  tx_out,  0);
    check("pre-rst busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    check("async rst out",  tx_out,  1);
    check("async rst busy", tx_busy, 0);
    check("async rst done", tx_done, 0);
    tx_start = 1'b1;
    repeat (2) begin
      tick;
      check("rst-wins out",  tx_out,  1);
      check("rst-wins busy", tx_busy, 0);
      check("rst-wins done", tx_done, 0);
    end
    tx_start = 1'b0;
    rst = 1'b0;
    tick;
    check_idle("rst-release");
    run_frame("post-rst", 8'h3C, model_frame(8'h3C), -1, 1'b0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 3);
      run_frame($sformatf("rnd%0d_%02h", i, d), d, model_frame(d), -1, 1'b0, 8'h00);
      repeat (gap) begin
        tick;
        check_idle("rnd-gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
